// File: rtl/beat_sequencer.sv
// beat_sequencer: machine-cycle beat generator for the hardwired CPU controller.
// Produces one-hot beats w1/w2/w3 per machine cycle; cycle length follows the
// controller's short/long requests, and execution is started by a synchronized
// front-panel qd edge and halted by stop or step_mode at cycle end.
module beat_sequencer #(
  parameter int CNT_W   = 16,
  parameter int QD_SYNC = 2    // synchronizer depth on qd, must be at least 2
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             qd,
  input  logic             step_mode,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             cyc_end,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    W2   = 2'd2,
    W3   = 2'd3
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [QD_SYNC-1:0] qd_sync_reg;
  logic               qd_dly_reg;
  logic               qd_rise;
  logic [CNT_W-1:0]   cnt_reg;

  // Synchronize the asynchronous qd level, then delay once more for edge detect
  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      qd_sync_reg <= '0;
      qd_dly_reg  <= 1'b0;
    end else begin
      qd_sync_reg <= {qd_sync_reg[QD_SYNC-2:0], qd};
      qd_dly_reg  <= qd_sync_reg[QD_SYNC-1];
    end
  end

  // A held-high qd yields a single pulse; a new start needs qd low then high
  assign qd_rise = qd_sync_reg[QD_SYNC-1] & ~qd_dly_reg;

  // Beat state register
  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next beat and last-beat detection; stop/step_mode only matter at cycle end
  always_comb begin
    state_next = state_reg;
    cyc_end    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (qd_rise) begin
          state_next = W1;
        end
      end
      W1: begin
        // short has priority over long: a short cycle never reaches W2
        if (short) begin
          cyc_end = 1'b1;
        end else begin
          state_next = W2;
        end
      end
      W2: begin
        if (!long) begin
          cyc_end = 1'b1;
        end else begin
          state_next = W3;
        end
      end
      W3: begin
        cyc_end = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (cyc_end) begin
      state_next = (stop || step_mode) ? IDLE : W1;
    end
  end

  // Count completed machine cycles, wrapping naturally at the counter width
  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      cnt_reg <= '0;
    end else if (cyc_end) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Beats decode straight from the registered state, so they are glitch-free
  always_comb begin
    w1      = (state_reg == W1);
    w2      = (state_reg == W2);
    w3      = (state_reg == W3);
    running = (state_reg != IDLE);
  end

  assign cycle_cnt = cnt_reg;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed stimulus with hand-computed expectations pushed
// into a scoreboard queue; a monitor pops and compares once per t3 period.
// A second instance with a 2-bit counter shares all inputs to exercise wrap.
module tb_beat_sequencer;

  logic        t3;
  logic        clr;
  logic        qd;
  logic        step_mode;
  logic        short;
  logic        long;
  logic        stop;
  logic        w1, w2, w3, cyc_end, running;
  logic [15:0] cycle_cnt;
  logic        w1_n, w2_n, w3_n, cyc_end_n, running_n;
  logic [1:0]  cycle_cnt_n;

  typedef struct {
    logic [2:0] b;     // expected {w3,w2,w1}
    logic       ce;    // expected cyc_end
    int         cnt;   // expected completed-cycle count (unwrapped)
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;
  event mon_ev;

  beat_sequencer #(.CNT_W(16), .QD_SYNC(2)) dut (
    .t3(t3), .clr(clr), .qd(qd), .step_mode(step_mode),
    .short(short), .long(long), .stop(stop),
    .w1(w1), .w2(w2), .w3(w3), .cyc_end(cyc_end), .running(running),
    .cycle_cnt(cycle_cnt)
  );

  beat_sequencer #(.CNT_W(2), .QD_SYNC(2)) dut_narrow (
    .t3(t3), .clr(clr), .qd(qd), .step_mode(step_mode),
    .short(short), .long(long), .stop(stop),
    .w1(w1_n), .w2(w2_n), .w3(w3_n), .cyc_end(cyc_end_n), .running(running_n),
    .cycle_cnt(cycle_cnt_n)
  );

  initial t3 = 1'b0;
  always #5 t3 = ~t3;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: compare whatever expectations are pending at each sample point
  initial begin
    exp_t e;
    forever begin
      @(negedge t3 or mon_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        txn++;
        $display("txn %0d t=%0t beats=%b cyc_end=%b running=%b cnt=%0d cnt2=%0d",
                 txn, $time, {w3, w2, w1}, cyc_end, running, cycle_cnt, cycle_cnt_n);
        chk("beats",      int'({w3, w2, w1}),     int'(e.b));
        chk("cyc_end",    int'(cyc_end),          int'(e.ce));
        chk("running",    int'(running),          int'(|e.b));
        chk("cycle_cnt",  int'(cycle_cnt),        e.cnt % 65536);
        chk("beats_w2",   int'({w3_n, w2_n, w1_n}), int'(e.b));
        chk("cnt_wrap",   int'(cycle_cnt_n),      e.cnt % 4);
        chk("cyc_end_w2", int'(cyc_end_n),        int'(e.ce));
        chk("running_w2", int'(running_n),        int'(|e.b));
      end
    end
  end

  // One t3 period: drive inputs for the coming edge, expect current state
  task automatic cyc(input logic c, input logic qv, input logic sm, input logic sh,
                     input logic lg, input logic sp, input logic [2:0] b,
                     input logic ce, input int cnt);
    exp_t e;
    @(posedge t3);
    #2;
    clr = c; qd = qv; step_mode = sm; short = sh; long = lg; stop = sp;
    e.b = b; e.ce = ce; e.cnt = cnt;
    q.push_back(e);
  endtask

  // Drop clr between edges and expect outputs cleared before the next edge
  task automatic async_drop();
    exp_t e;
    @(negedge t3);
    #2;
    clr = 1'b0;
    #1;
    e.b = 3'b000; e.ce = 1'b0; e.cnt = 0;
    q.push_back(e);
    -> mon_ev;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b0; qd = 1'b0; step_mode = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;

    // Reset held with qd toggling, then release and stay idle
    cyc(0,1,0,0,0,0, 3'b000,0,0);
    cyc(0,0,0,0,0,0, 3'b000,0,0);
    cyc(0,1,0,0,0,0, 3'b000,0,0);
    for (int i = 0; i < 10; i++) cyc(1,0,0,0,0,0, 3'b000,0,0);

    // Free run, two-beat cycles; w1 two edges after qd is sampled
    cyc(1,1,0,0,0,0, 3'b000,0,0);
    cyc(1,0,0,0,0,0, 3'b000,0,0);
    cyc(1,0,0,0,0,0, 3'b000,0,0);
    for (int k = 0; k < 4; k++) begin
      cyc(1,0,0,0,0,0, 3'b001,0,k);
      cyc(1,0,0,0,0,0, 3'b010,1,k);
    end

    // Long cycles W1,W2,W3
    cyc(1,0,0,0,1,0, 3'b001,0,4);
    cyc(1,0,0,0,1,0, 3'b010,0,4);
    cyc(1,0,0,0,1,0, 3'b100,1,4);
    cyc(1,0,0,0,1,0, 3'b001,0,5);
    cyc(1,0,0,0,1,0, 3'b010,0,5);
    cyc(1,0,0,0,1,0, 3'b100,1,5);
    // Short wins over long: one-beat cycles
    cyc(1,0,0,1,1,0, 3'b001,1,6);
    cyc(1,0,0,1,1,0, 3'b001,1,7);
    cyc(1,0,0,0,0,0, 3'b001,0,8);
    // W2 about to end, then asynchronous reset before the edge
    cyc(1,0,0,0,0,0, 3'b010,1,8);
    async_drop();
    cyc(0,0,0,0,0,0, 3'b000,0,0);
    cyc(1,0,0,0,0,0, 3'b000,0,0);
    cyc(1,0,0,0,0,0, 3'b000,0,0);

    // Single step with qd held high: exactly one cycle
    cyc(1,1,1,0,0,0, 3'b000,0,0);
    cyc(1,1,1,0,0,0, 3'b000,0,0);
    cyc(1,1,1,0,0,0, 3'b000,0,0);
    cyc(1,1,1,0,0,0, 3'b001,0,0);
    cyc(1,1,1,0,0,0, 3'b010,1,0);
    for (int i = 0; i < 20; i++) cyc(1,1,1,0,0,0, 3'b000,0,1);
    for (int i = 0; i < 3; i++)  cyc(1,0,1,0,0,0, 3'b000,0,1);
    // Fresh press gives one more cycle
    cyc(1,1,1,0,0,0, 3'b000,0,1);
    cyc(1,0,1,0,0,0, 3'b000,0,1);
    cyc(1,0,1,0,0,0, 3'b000,0,1);
    cyc(1,0,1,0,0,0, 3'b001,0,1);
    cyc(1,0,1,0,0,0, 3'b010,1,1);
    cyc(1,0,0,0,0,0, 3'b000,0,2);

    // Free run; stop raised in W1 of the third cycle, honored at end of W2
    cyc(1,1,0,0,0,0, 3'b000,0,2);
    cyc(1,0,0,0,0,0, 3'b000,0,2);
    cyc(1,0,0,0,0,0, 3'b000,0,2);
    cyc(1,0,0,0,0,0, 3'b001,0,2);
    cyc(1,0,0,0,0,0, 3'b010,1,2);
    cyc(1,0,0,0,0,0, 3'b001,0,3);
    cyc(1,0,0,0,0,0, 3'b010,1,3);
    cyc(1,0,0,0,0,1, 3'b001,0,4);
    cyc(1,0,0,0,0,1, 3'b010,1,4);
    cyc(1,0,0,0,0,0, 3'b000,0,5);
    cyc(1,0,0,0,0,0, 3'b000,0,5);

    // All expectations must have been consumed by the monitor
    @(negedge t3);
    #3;
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
